// File: rtl/sram_fib_pkg.sv
// Shared definitions for the SRAM Fibonacci controller.
// Holds the default geometry / latency constants and the FSM state encoding
// used by sram_fib_ctrl. No ports; imported by every file of this block.
package sram_fib_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_READ_LAT   = 2;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_WRITE   = 3'd1;
  localparam logic [STATE_W-1:0] ST_RD_ADDR = 3'd2;
  localparam logic [STATE_W-1:0] ST_RD_WAIT = 3'd3;
  localparam logic [STATE_W-1:0] ST_OUT     = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd5;

endpackage

// File: rtl/sram_fib_gen.sv
// fib_gen: Fibonacci term generator holding the two running terms a/b.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (a = b = 0)
//   load        - restart the sequence: a = 0, b = 1
//   advance     - step the sequence: a <= b, b <= a + b (wraps mod 2^DATA_WIDTH)
//   term        - current term a
// load has priority over advance.
module fib_gen
  import sram_fib_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] term
);

  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (load) begin
      a_d = '0;
      b_d = DATA_WIDTH'(1);
    end else if (advance) begin
      a_d = b_q;
      b_d = a_q + b_q;  // natural modulo 2^DATA_WIDTH wrap
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign term = a_q;

endmodule

// File: rtl/sram_fib_ctrl.sv
// sram_fib_ctrl: writes Fibonacci terms 0..last_idx into an external SRAM,
// then reads them back one at a time and streams them out with a
// valid/ready handshake.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset (aborts a job)
//   start, last_idx     - job request and index of the final term
//   mem_we, mem_oe      - SRAM write / output enable (never both high)
//   mem_addr, mem_wdata - SRAM address and write data
//   mem_rdata           - SRAM registered read data, valid READ_LAT cycles
//                         after the address is presented
//   out_data, out_valid, out_ready, out_last - term stream
//   busy, done          - job in progress / one-cycle completion pulse
// All outputs are decoded from registered state, so they go to 0 the moment
// rst_n falls. READ_LAT must be at least 1.
module sram_fib_ctrl
  import sram_fib_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int READ_LAT   = DEF_READ_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] last_idx,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  // Wait counter runs 0..READ_LAT-1 inside RD_WAIT.
  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(READ_LAT - 1);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [CNT_W-1:0]      wait_q, wait_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                  fib_load;
  logic                  fib_advance;
  logic [DATA_WIDTH-1:0] fib_term;

  fib_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fib_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (fib_load),
    .advance(fib_advance),
    .term   (fib_term)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    wait_d      = wait_q;
    out_data_d  = out_data_q;
    fib_load    = 1'b0;
    fib_advance = 1'b0;
    mem_we      = 1'b0;
    mem_oe      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          last_d   = last_idx;
          idx_d    = '0;
          fib_load = 1'b1;
          state_d  = ST_WRITE;
        end
      end

      ST_WRITE: begin
        busy        = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = idx_q;
        mem_wdata   = fib_term;
        fib_advance = 1'b1;
        if (idx_q == last_q) begin
          idx_d   = '0;
          state_d = ST_RD_ADDR;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_RD_ADDR: begin
        busy     = 1'b1;
        mem_oe   = 1'b1;
        mem_addr = idx_q;
        wait_d   = '0;
        state_d  = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        busy     = 1'b1;
        mem_oe   = 1'b1;
        mem_addr = idx_q;
        // Read data becomes valid in the final wait cycle; capture it there.
        if (wait_q == LAST_WAIT) begin
          out_data_d = mem_rdata;
          state_d    = ST_OUT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      ST_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_last  = (idx_q == last_q);
        if (out_ready) begin
          if (idx_q == last_q) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_RD_ADDR;
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      wait_q     <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      wait_q     <= wait_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_sram_fib_ctrl.sv
// Self-checking bench for sram_fib_ctrl. Contains a behavioural SRAM with
// READ_LAT registered read stages and a reference model that computes the
// Fibonacci terms with plain modular arithmetic and tracks the expected
// write / read / stream sequence per job.
module tb_sram_fib_ctrl;

  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int RL   = 2;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] last_idx;
  logic          mem_we, mem_oe;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, out_last;
  logic          busy, done;

  int compared   = 0;
  int mismatched = 0;

  sram_fib_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .last_idx (last_idx),
    .mem_we   (mem_we),
    .mem_oe   (mem_oe),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: synchronous write, READ_LAT-stage registered read.
  logic [DW-1:0] sram [2**AW];
  logic [DW-1:0] rd_pipe [RL];

  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_wdata;
    if (mem_oe) rd_pipe[0] <= sram[mem_addr];
    for (int s = 1; s < RL; s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign mem_rdata = rd_pipe[RL-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference sequence: term i of the Fibonacci series modulo 2^DW.
  int fib [2**AW];
  task automatic build_fib();
    int a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < 2**AW; i++) begin
      fib[i] = a;
      t = (a + b) % (2**DW);
      a = b;
      b = t;
    end
  endtask

  // mode: 0 = out_ready always 1, 1 = 1-0-0-1 pattern, 2 = random.
  task automatic run_job(input int last, input int mode, input bit inject);
    int  writes, reads, outs, cyc, oe_run, oe_addr, k;
    bit  finished, stalled, inj_w, inj_o;
    logic [DW-1:0] held;
    bit  pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    writes = 0; reads = 0; outs = 0; cyc = 0; oe_run = 0; oe_addr = 0; k = 0;
    finished = 0; stalled = 0; inj_w = 0; inj_o = 0; held = '0;

    start    = 1'b1;
    last_idx = AW'(last);
    tick();
    start = 1'b0;

    while (!finished && cyc < BUDGET) begin
      cyc++;
      if (mem_we && mem_oe) check("we_oe_exclusive", 1, 0);

      if (mem_we) begin
        check("wr_addr", 32'(mem_addr), writes);
        check("wr_data", 32'(mem_wdata), fib[writes]);
        writes++;
      end

      if (mem_oe) begin
        if (oe_run == 0) oe_addr = int'(mem_addr);
        else check("rd_addr_hold", 32'(mem_addr), oe_addr);
        oe_run++;
      end else if (oe_run > 0) begin
        check("rd_oe_len", oe_run, 1 + RL);
        check("rd_addr_order", oe_addr, reads);
        reads++;
        oe_run = 0;
      end

      if (!mem_we && !mem_oe) begin
        if (mem_addr !== '0)  check("idle_addr", 32'(mem_addr), 0);
        if (mem_wdata !== '0) check("idle_wdata", 32'(mem_wdata), 0);
      end

      if (done) begin
        check("done_busy", 32'(busy), 0);
        check("done_writes", writes, last + 1);
        check("done_outs", outs, last + 1);
        check("done_reads", reads, last + 1);
        check("done_we", 32'(mem_we), 0);
        check("done_valid", 32'(out_valid), 0);
        finished = 1;
      end else begin
        if (!busy) check("busy_high", 32'(busy), 1);
        if (out_valid) begin
          check("out_data", 32'(out_data), fib[outs]);
          check("out_last", 32'(out_last), 32'(outs == last));
          if (stalled) check("stall_stable", 32'(out_data), 32'(held));
        end

        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = pat[k % 4];
          default: out_ready = 1'($urandom);
        endcase
        k++;

        if (out_valid && out_ready) begin
          outs++;
          stalled = 0;
        end else if (out_valid) begin
          stalled = 1;
          held    = out_data;
        end

        start = 1'b0;
        if (inject) begin
          last_idx = AW'($urandom);
          if (mem_we && writes == 2 && !inj_w) begin start = 1'b1; inj_w = 1; end
          if (out_valid && outs == 1 && !inj_o) begin start = 1'b1; inj_o = 1; end
        end
        tick();
      end
    end
    start = 1'b0;
    if (!finished) check("job_timeout", 0, 1);
    // The done pulse lasts exactly one cycle and the block is idle afterwards.
    tick();
    check("done_pulse_once", 32'(done), 0);
    check("idle_after_done", 32'(busy), 0);
  endtask

  initial begin
    int wait_cyc;
    build_fib();
    rst_n     = 1'b0;
    start     = 1'b0;
    last_idx  = '0;
    out_ready = 1'b0;
    #23;
    check("rst_we", 32'(mem_we), 0);
    check("rst_oe", 32'(mem_oe), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    rst_n = 1'b1;

    // Full 16-term job with the wrap at terms 14/15, always ready.
    run_job(15, 0, 0);
    // Single-term job.
    run_job(0, 0, 0);
    // Stalling consumer.
    run_job(7, 1, 0);
    // Start pulses and last_idx changes while busy must be ignored.
    run_job(5, 2, 1);

    // Abort mid-write at address 5, then restart immediately after release.
    start    = 1'b1;
    last_idx = AW'(10);
    tick();
    start    = 1'b0;
    wait_cyc = 0;
    while (!(mem_we && mem_addr == AW'(5)) && wait_cyc < 50) begin
      tick();
      wait_cyc++;
    end
    check("abort_reached_idx5", 32'(mem_addr), 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_we", 32'(mem_we), 0);
    check("abort_addr", 32'(mem_addr), 0);
    check("abort_wdata", 32'(mem_wdata), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_out_data", 32'(out_data), 0);
    #2;
    rst_n = 1'b1;
    run_job(3, 0, 0);

    // Randomised jobs.
    for (int j = 0; j < 4; j++) begin
      run_job(int'($urandom_range(0, 2**AW - 1)), int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
